// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Package  : regfile_pkg
// Purpose  : Shared register-file widths and the write-request record.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int unsigned DEF_N_BIT_DATA    = 32;
    localparam int unsigned DEF_N_BIT_ADDRESS = 16;

    typedef struct packed {
        logic [DEF_N_BIT_ADDRESS-1:0] address;
        logic [DEF_N_BIT_DATA-1:0]    data;
    } write_request_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_issue_select.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_issue_select
// Purpose  : Sizes the issue group from the oldest pending entries, stopping
//            before the first address repeated earlier in the group.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_issue_select
    import regfile_pkg::*;
#(
    parameter int N_BIT_ADDRESS = DEF_N_BIT_ADDRESS,
    parameter int N_WRITE       = 4
) (
    input  logic [N_WRITE-1:0]           i_avail,
    input  logic [N_BIT_ADDRESS-1:0]     i_address [N_WRITE],
    output logic [$clog2(N_WRITE+1)-1:0] o_group_size
);

    localparam int GRP_W = $clog2(N_WRITE+1);

    always_comb begin
        logic w_stop;
        logic w_dup;
        o_group_size = '0;
        w_stop       = 1'b0;
        w_dup        = 1'b0;
        for (int k = 0; k < N_WRITE; k++) begin
            w_dup = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (i_address[j] == i_address[k]) begin
                    w_dup = 1'b1;
                end
            end
            // Once the group is cut, younger entries may not join it.
            if (!i_avail[k] || w_dup) begin
                w_stop = 1'b1;
            end
            if (!w_stop) begin
                o_group_size = GRP_W'(k + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_buffer
// Purpose  : In-order circular write queue draining up to N_WRITE register-file
//            writes per cycle, with youngest-match read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_buffer
    import regfile_pkg::*;
#(
    parameter int N_BIT_DATA    = DEF_N_BIT_DATA,
    parameter int N_BIT_ADDRESS = DEF_N_BIT_ADDRESS,
    parameter int N_WRITE       = 4,
    parameter int DEPTH         = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_BIT_ADDRESS-1:0]   in_address,
    input  logic [N_BIT_DATA-1:0]      in_data,
    input  logic                       drain_enable,
    output logic                       write         [N_WRITE],
    output logic [N_BIT_ADDRESS-1:0]   address_write [N_WRITE],
    output logic [N_BIT_DATA-1:0]      data_in       [N_WRITE],
    input  logic [N_BIT_ADDRESS-1:0]   lookup_address,
    output logic                       lookup_hit,
    output logic [N_BIT_DATA-1:0]      lookup_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int GRP_W = $clog2(N_WRITE+1);

    // Storage is deliberately unreset; validity comes from r_count alone.
    logic [N_BIT_ADDRESS-1:0] r_addr [DEPTH];
    logic [N_BIT_DATA-1:0]    r_data [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;

    logic                     w_push;
    logic                     w_drain;
    logic [GRP_W-1:0]         w_group_size;
    logic [GRP_W-1:0]         w_n_issue;
    logic [N_WRITE-1:0]       w_avail;
    logic [PTR_W-1:0]         w_gidx  [N_WRITE];
    logic [N_BIT_ADDRESS-1:0] w_gaddr [N_WRITE];
    logic [PTR_W-1:0]         w_lk_idx;

    assign in_ready  = reset_n && (r_count < CNT_W'(DEPTH));
    assign w_push    = in_valid && in_ready;
    assign w_drain   = reset_n && drain_enable && (r_count != '0);
    assign w_n_issue = w_drain ? w_group_size : '0;
    assign count     = r_count;

    generate
        for (genvar k = 0; k < N_WRITE; k++) begin : g_port
            assign w_gidx[k]        = r_rd_ptr + PTR_W'(k);
            assign w_avail[k]       = (r_count > CNT_W'(k));
            assign w_gaddr[k]       = r_addr[w_gidx[k]];
            assign write[k]         = w_drain && (GRP_W'(k) < w_group_size);
            assign address_write[k] = write[k] ? w_gaddr[k] : '0;
            assign data_in[k]       = write[k] ? r_data[w_gidx[k]] : '0;
        end
    endgenerate

    regfile_write_issue_select #(
        .N_BIT_ADDRESS (N_BIT_ADDRESS),
        .N_WRITE       (N_WRITE)
    ) u_issue_select (
        .i_avail      (w_avail),
        .i_address    (w_gaddr),
        .o_group_size (w_group_size)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_issue);
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_n_issue);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= in_address;
            r_data[r_wr_ptr] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        w_lk_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_lk_idx = r_rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_addr[w_lk_idx] == lookup_address)) begin
                lookup_hit  = 1'b1;
                lookup_data = r_data[w_lk_idx];
            end
        end
    end

endmodule
`default_nettype wire
